// File: rtl/measure_seq.sv
// measure_seq: sequencer for the DFM measure datapath.
//
// Runs a finite number of back-to-back gated measurements, or runs continuously when the
// run count is 0. It arms the measure block, captures each {ref_cnt,sig_cnt} result and
// presents it on a valid/ready stream.
//
// Optional feature: define MEASURE_SEQ_TIMEOUT_EN to enable the per-measurement timeout.
// Without it, cfg_tmo_i is ignored and tmo_o is tied low.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   cfg_start_i         start pulse; ignored while busy
//   cfg_stop_i          abort pulse; wins over a simultaneous start
//   cfg_runs_i          measurements per start (0 = continuous)
//   cfg_gate_i          gate length in signal periods, latched at start
//   cfg_tmo_i           per-measurement timeout in clk cycles (0 = disabled)
//   gate_en_o           arm request to measure
//   gate_total_o        gate length to measure, held for the whole run
//   gate_sync_i         measure gate-open indication
//   meas_wr_en_i        1-cycle result strobe from measure
//   meas_data_i         result from measure {ref_cnt,sig_cnt}
//   res_valid_o         result stream valid
//   res_ready_i         result stream ready
//   res_data_o          result stream data
//   res_idx_o           0-based index of the result within the run
//   busy_o              sequencer not idle
//   done_o              1-cycle pulse when a finite run completes and its last result is taken
//   ovf_o               sticky: a result was dropped because the output register was full
//   tmo_o               sticky: a measurement timed out
module measure_seq #(
  parameter int unsigned RUN_W = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cfg_start_i,
  input  logic             cfg_stop_i,
  input  logic [RUN_W-1:0] cfg_runs_i,
  input  logic [CNT_W-1:0] cfg_gate_i,
  input  logic [CNT_W-1:0] cfg_tmo_i,
  output logic             gate_en_o,
  output logic [CNT_W-1:0] gate_total_o,
  input  logic             gate_sync_i,
  input  logic             meas_wr_en_i,
  input  logic [63:0]      meas_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [63:0]      res_data_o,
  output logic [RUN_W-1:0] res_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic             tmo_o
);

  typedef enum logic [2:0] {StIdle, StArm, StGate, StFlush, StStop} state_e;

  state_e           state_q;
  logic [RUN_W-1:0] runs_q;
  logic [RUN_W-1:0] run_cnt_q;
  logic [1:0]       stop_cnt_q;

  logic             accept;
  logic             out_free;
  logic             last_run;
  logic             tmo_hit;
  logic [RUN_W-1:0] run_cnt_inc;

  assign accept      = res_valid_o & res_ready_i;
  // The output register can take a new result if empty or being emptied this cycle.
  assign out_free    = ~res_valid_o | res_ready_i;
  assign run_cnt_inc = run_cnt_q + RUN_W'(1);
  assign last_run    = (runs_q != '0) && (run_cnt_inc == runs_q);

`ifdef MEASURE_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cfg_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_q;

  assign tmo_hit = (tmo_cfg_q != '0) && (tmo_cnt_q == tmo_cfg_q);
  assign tmo_o   = tmo_q;
`else
  logic unused_tmo;

  assign unused_tmo = ^cfg_tmo_i;
  assign tmo_hit    = 1'b0;
  assign tmo_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      runs_q       <= '0;
      run_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      gate_en_o    <= 1'b0;
      gate_total_o <= '0;
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      res_idx_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      ovf_o        <= 1'b0;
`ifdef MEASURE_SEQ_TIMEOUT_EN
      tmo_cfg_q    <= '0;
      tmo_cnt_q    <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      // A result pending from an aborted run is still handed out from any state.
      if (accept) begin
        res_valid_o <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (cfg_start_i && !cfg_stop_i) begin
            runs_q       <= cfg_runs_i;
            gate_total_o <= cfg_gate_i;
            run_cnt_q    <= '0;
            ovf_o        <= 1'b0;
            gate_en_o    <= 1'b1;
            busy_o       <= 1'b1;
            state_q      <= StArm;
`ifdef MEASURE_SEQ_TIMEOUT_EN
            tmo_cfg_q    <= cfg_tmo_i;
            tmo_cnt_q    <= '0;
            tmo_q        <= 1'b0;
`endif
          end
        end

        StArm: begin
          if (cfg_stop_i || tmo_hit) begin
            gate_en_o  <= 1'b0;
            stop_cnt_q <= '0;
            state_q    <= StStop;
`ifdef MEASURE_SEQ_TIMEOUT_EN
            if (tmo_hit) begin
              tmo_q <= 1'b1;
            end
`endif
          end else begin
`ifdef MEASURE_SEQ_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
            // Drop the arm request once the gate opens so measure does not re-arm when it closes.
            if (gate_sync_i) begin
              gate_en_o <= 1'b0;
              state_q   <= StGate;
            end
          end
        end

        StGate: begin
          if (cfg_stop_i || tmo_hit) begin
            gate_en_o  <= 1'b0;
            stop_cnt_q <= '0;
            state_q    <= StStop;
`ifdef MEASURE_SEQ_TIMEOUT_EN
            if (tmo_hit) begin
              tmo_q <= 1'b1;
            end
`endif
          end else if (meas_wr_en_i) begin
            if (out_free) begin
              res_valid_o <= 1'b1;
              res_data_o  <= meas_data_i;
              res_idx_o   <= run_cnt_q;
            end else begin
              ovf_o <= 1'b1;
            end
            run_cnt_q <= run_cnt_inc;
            if (last_run) begin
              state_q <= StFlush;
            end else begin
              gate_en_o <= 1'b1;
              state_q   <= StArm;
`ifdef MEASURE_SEQ_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end else begin
`ifdef MEASURE_SEQ_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
          end
        end

        StFlush: begin
          if (cfg_stop_i) begin
            stop_cnt_q <= '0;
            state_q    <= StStop;
          end else if (out_free) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end
        end

        StStop: begin
          // Wait for the measure gate to stay closed for four consecutive cycles.
          if (gate_sync_i) begin
            stop_cnt_q <= '0;
          end else if (stop_cnt_q == 2'd3) begin
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end else begin
            stop_cnt_q <= stop_cnt_q + 2'd1;
          end
        end

        default: begin
          gate_en_o <= 1'b0;
          busy_o    <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_measure_seq.sv
module tb_measure_seq;
  localparam int unsigned RUN_W = 8;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop;
  logic [RUN_W-1:0] cfg_runs;
  logic [CNT_W-1:0] cfg_gate, cfg_tmo;
  logic             gate_en;
  logic [CNT_W-1:0] gate_total;
  logic             gate_sync;
  logic             wr_en;
  logic [63:0]      wr_data;
  logic             res_valid, res_ready;
  logic [63:0]      res_data;
  logic [RUN_W-1:0] res_idx;
  logic             busy, done, ovf, tmo;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  measure_seq #(.RUN_W(RUN_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_start_i(start), .cfg_stop_i(stop),
    .cfg_runs_i(cfg_runs), .cfg_gate_i(cfg_gate), .cfg_tmo_i(cfg_tmo),
    .gate_en_o(gate_en), .gate_total_o(gate_total), .gate_sync_i(gate_sync),
    .meas_wr_en_i(wr_en), .meas_data_i(wr_data), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .res_data_o(res_data), .res_idx_o(res_idx),
    .busy_o(busy), .done_o(done), .ovf_o(ovf), .tmo_o(tmo)
  );

  // Behavioural measure block: sig_clk = clk/10. Once armed, the gate opens on a signal edge
  // and closes after gate_total+1 signal periods, counting reference cycles meanwhile.
  logic        sig_run;
  int          ph;
  logic        m_active;
  logic [31:0] m_sig, m_ref;
  wire         sig_tick = sig_run && (ph == 9);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; m_active <= 1'b0; m_sig <= '0; m_ref <= '0;
      gate_sync <= 1'b0; wr_en <= 1'b0; wr_data <= '0;
    end else begin
      ph    <= (ph == 9) ? 0 : ph + 1;
      wr_en <= 1'b0;
      if (m_active) begin
        m_ref <= m_ref + 32'd1;
        m_sig <= m_sig + {31'd0, sig_tick};
        if (sig_tick && (m_sig + 32'd1 == gate_total + 32'd1)) begin
          m_active  <= 1'b0;
          gate_sync <= 1'b0;
          wr_en     <= 1'b1;
          wr_data   <= {m_ref + 32'd1, m_sig + 32'd1};
        end
      end else if (gate_en && sig_tick) begin
        m_active <= 1'b1; gate_sync <= 1'b1; m_sig <= '0; m_ref <= '0;
      end
    end
  end

  // Scoreboard of accepted stream beats {idx,data} and done pulses.
  logic [RUN_W+63:0] acc_q[$];
  int                done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) acc_q.push_back({res_idx, res_data});
    if (done) done_cnt++;
  end

  function automatic logic [63:0] exp_data(input logic [31:0] g);
    exp_data = {(g + 32'd1) * 32'd10, g + 32'd1};
  endfunction

  task automatic do_start(input logic [RUN_W-1:0] r, input logic [31:0] g, input logic [31:0] t);
    @(posedge clk); #1;
    cfg_runs = r; cfg_gate = g; cfg_tmo = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [CNT_W+RUN_W+70:0] outs;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; res_ready = 1'b1; sig_run = 1'b1;
    cfg_runs = '0; cfg_gate = '0; cfg_tmo = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    outs = {gate_en, gate_total, res_valid, res_data, res_idx, busy, done, ovf, tmo};
    vecs++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", outs); end
  endtask

  task automatic test_finite_run();
    logic [31:0] g = $urandom_range(5, 30);
    logic [RUN_W-1:0] r = RUN_W'($urandom_range(1, 4));
    int d0 = done_cnt;
    bit ok;
    acc_q.delete();
    do_start(r, g, 0);
    @(negedge clk);
    vecs++;
    if ({gate_en, busy, gate_total} !== {1'b1, 1'b1, g}) begin
      errs++; $display("FAIL start_arm: gate_en=%b busy=%b total=%0d want 1 1 %0d",
                       gate_en, busy, gate_total, g);
    end
    wait_done(int'(r) * (int'(g) + 3) * 10 + 200, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL finite_done: no done_o within budget"); end
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if (acc_q.size() != int'(r)) begin
      errs++; $display("FAIL finite_count: got %0d results want %0d", acc_q.size(), r);
    end
    for (int i = 0; i < int'(r) && i < acc_q.size(); i++) begin
      vecs++;
      if (acc_q[i] !== {RUN_W'(i), exp_data(g)}) begin
        errs++; $display("FAIL finite_result[%0d]: got %h want %h", i, acc_q[i],
                         {RUN_W'(i), exp_data(g)});
      end
    end
    vecs++;
    if ({done_cnt - d0, busy, ovf} !== {32'd1, 1'b0, 1'b0}) begin
      errs++; $display("FAIL finite_end: done pulses=%0d busy=%b ovf=%b want 1 0 0",
                       done_cnt - d0, busy, ovf);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] g = $urandom_range(5, 20);
    int d0 = done_cnt;
    bit ok = 1'b0;
    acc_q.delete();
    res_ready = 1'b0;
    do_start(2, g, 0);
    for (int i = 0; i < 2 * (int'(g) + 3) * 10 + 200; i++) begin
      @(negedge clk);
      if (ovf) begin ok = 1'b1; break; end
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL ovf_set: ovf_o never rose"); end
    repeat (5) @(negedge clk);
    vecs++;
    if ({res_valid, res_idx, res_data, busy} !== {1'b1, RUN_W'(0), exp_data(g), 1'b1}) begin
      errs++; $display("FAIL ovf_held: valid=%b idx=%0d data=%h busy=%b want 1 0 %h 1",
                       res_valid, res_idx, res_data, busy, exp_data(g));
    end
    vecs++;
    if (done_cnt != d0) begin errs++; $display("FAIL ovf_early_done: got %0d want 0", done_cnt - d0); end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done(50, ok);
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (!ok || acc_q.size() != 1) begin
      errs++; $display("FAIL ovf_accept: done=%b results=%0d want 1 1", ok, acc_q.size());
    end else if (acc_q[0] !== {RUN_W'(0), exp_data(g)}) begin
      errs++; $display("FAIL ovf_accept_data: got %h want %h", acc_q[0], {RUN_W'(0), exp_data(g)});
    end
    vecs++;
    if ({ovf, busy} !== 2'b10) begin
      errs++; $display("FAIL ovf_sticky: ovf=%b busy=%b want 1 0", ovf, busy);
    end
  endtask

  task automatic test_continuous_stop();
    logic [31:0] g = $urandom_range(5, 20);
    int d0 = done_cnt;
    int low_run = 0;
    bit ok = 1'b0;
    acc_q.delete();
    do_start(0, g, 0);
    @(negedge clk);
    vecs++;
    if (ovf !== 1'b0) begin errs++; $display("FAIL start_clears_ovf: got %b want 0", ovf); end
    for (int i = 0; i < 5 * (int'(g) + 3) * 10 + 200; i++) begin
      @(negedge clk); #1;
      if (acc_q.size() >= 5) begin ok = 1'b1; break; end
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL cont_five: only %0d results", acc_q.size()); end
    pulse_stop();
    @(negedge clk);
    vecs++;
    if ({gate_en, busy} !== 2'b01) begin
      errs++; $display("FAIL stop_gate_en: gate_en=%b busy=%b want 0 1", gate_en, busy);
    end
    ok = 1'b0;
    low_run = gate_sync ? 0 : 1;
    for (int i = 0; i < (int'(g) + 3) * 10 + 50; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
      low_run = gate_sync ? 0 : low_run + 1;
    end
    vecs++;
    if (!ok || low_run != 4) begin
      errs++; $display("FAIL stop_exit: idle=%b low_cycles=%0d want 1 4", ok, low_run);
    end
    #1;
    vecs++;
    if (acc_q.size() != 5 || done_cnt != d0) begin
      errs++; $display("FAIL stop_results: results=%0d done=%0d want 5 0", acc_q.size(),
                       done_cnt - d0);
    end
    for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
      vecs++;
      if (acc_q[i] !== {RUN_W'(i), exp_data(g)}) begin
        errs++; $display("FAIL cont_result[%0d]: got %h want %h", i, acc_q[i],
                         {RUN_W'(i), exp_data(g)});
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] g = $urandom_range(5, 15);
    int d0 = done_cnt;
    int bad = 0;
    bit ok = 1'b0;
    acc_q.delete();
    do_start(3, g, 0);
    for (int i = 0; i < (int'(g) + 3) * 10 + 100; i++) begin
      @(negedge clk); #1;
      if (acc_q.size() >= 1) begin ok = 1'b1; break; end
    end
    do_start(1, g + 7, 0);
    @(negedge clk);
    vecs++;
    if (!ok || gate_total !== g || busy !== 1'b1) begin
      errs++; $display("FAIL busy_start: first=%b total=%0d busy=%b want 1 %0d 1", ok,
                       gate_total, busy, g);
    end
    wait_done(3 * (int'(g) + 3) * 10 + 200, ok);
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (!ok || acc_q.size() != 3 || done_cnt - d0 != 1) begin
      errs++; $display("FAIL busy_runs: done=%b results=%0d pulses=%0d want 1 3 1", ok,
                       acc_q.size(), done_cnt - d0);
    end
    for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
      vecs++;
      if (acc_q[i] !== {RUN_W'(i), exp_data(g)}) begin
        errs++; $display("FAIL busy_result[%0d]: got %h want %h", i, acc_q[i],
                         {RUN_W'(i), exp_data(g)});
      end
    end
    @(posedge clk); #1;
    cfg_runs = 1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || gate_en) bad++;
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL start_stop_idle: busy cycles=%0d want 0", bad); end
  endtask

  task automatic test_timeout();
    bit ok = 1'b0;
    int k = 0;
    int d0 = done_cnt;
    sig_run = 1'b0;
    do_start(1, 10, 1000);
`ifdef MEASURE_SEQ_TIMEOUT_EN
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); k++;
      if (tmo) break;
    end
    vecs++;
    if (tmo !== 1'b1 || k < 1000 || k > 1003) begin
      errs++; $display("FAIL tmo_fire: tmo=%b after %0d cycles want 1 after ~1000", tmo, k);
    end
    wait_idle(20, ok);
    vecs++;
    if (!ok || gate_en !== 1'b0 || done_cnt != d0) begin
      errs++; $display("FAIL tmo_idle: idle=%b gate_en=%b done=%0d want 1 0 0", ok, gate_en,
                       done_cnt - d0);
    end
`else
    repeat (1200) @(negedge clk);
    vecs++;
    if ({busy, gate_en, tmo} !== 3'b110) begin
      errs++; $display("FAIL tmo_hang: busy=%b gate_en=%b tmo=%b want 1 1 0", busy, gate_en, tmo);
    end
    pulse_stop();
    wait_idle(20, ok);
    vecs++;
    if (!ok || done_cnt != d0) begin
      errs++; $display("FAIL tmo_stop: idle=%b done=%0d want 1 0", ok, done_cnt - d0);
    end
`endif
    sig_run = 1'b1;
  endtask

  task automatic test_reset_mid_gate();
    logic [CNT_W+RUN_W+70:0] outs;
    logic [31:0] g = $urandom_range(5, 15);
    bit ok = 1'b0;
    do_start(2, g, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gate_sync) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {gate_en, gate_total, res_valid, res_data, res_idx, busy, done, ovf, tmo};
    vecs++;
    if (!ok || outs !== '0) begin
      errs++; $display("FAIL reset_mid: gated=%b outputs=%h want 1 0", ok, outs);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    acc_q.delete();
    do_start(2, g, 0);
    wait_done(2 * (int'(g) + 3) * 10 + 200, ok);
    #1;
    vecs++;
    if (!ok || acc_q.size() != 2) begin
      errs++; $display("FAIL reset_rerun: done=%b results=%0d want 1 2", ok, acc_q.size());
    end
    for (int i = 0; i < 2 && i < acc_q.size(); i++) begin
      vecs++;
      if (acc_q[i] !== {RUN_W'(i), exp_data(g)}) begin
        errs++; $display("FAIL rerun_result[%0d]: got %h want %h", i, acc_q[i],
                         {RUN_W'(i), exp_data(g)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_finite_run();
    test_finite_run();
    test_overflow();
    test_continuous_stop();
    test_start_while_busy();
    test_timeout();
    test_reset_mid_gate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
